// File: rtl/palette_encoder.sv
// Reverse palette lookup: RGB565 pixel pairs in, 8-bit palette index pairs out to memory.
// Define PALETTE_NEAREST_EN for nearest-colour search instead of exact match with DEFAULT_INDEX.
module palette_encoder #(
   parameter int NUM_ENTRIES   = 16,
   parameter int DEFAULT_INDEX = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        avs_slave_write,
   input  logic [23:0] avs_slave_address,
   input  logic [31:0] avs_slave_writedata,
   output logic        avs_slave_waitrequest,
   output logic        avm_master_write,
   output logic [23:0] avm_master_address,
   output logic [15:0] avm_master_writedata,
   input  logic        avm_master_waitrequest,
   input  logic [7:0]  avs_palette_address,
   input  logic [15:0] avs_palette_writedata,
   input  logic        avs_palette_write,
   output logic [15:0] avs_palette_readdata,
   output logic [1:0]  fsm_state_o
);

   localparam int            CW   = $clog2(NUM_ENTRIES) + 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_ENTRIES - 1);
   localparam logic [7:0]    DEF8 = 8'(DEFAULT_INDEX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      WRITE  = 2'd2
   } state_t;

   // Handshake: a slave write is taken on any edge where avs_slave_write=1 and
   // avs_slave_waitrequest=0; a master write completes on the first edge where
   // avm_master_write=1 and avm_master_waitrequest=0.

   state_t        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [15:0]   pix_a_q, pix_a_d, pix_b_q, pix_b_d;
   logic [7:0]    idx_a_q, idx_a_d, idx_b_q, idx_b_d;
   logic          mwrite_q, mwrite_d;
   logic [23:0]   maddr_q, maddr_d;
   logic [15:0]   mdata_q, mdata_d;
   logic [15:0]   rdata_q;

   // Palette contents come from the configuration image; reset leaves them alone.
   logic [15:0] pal_q [0:255] = '{
      0: 16'h0000, 1: 16'hFFFF, 2: 16'hF800, 3: 16'h07E0,
      4: 16'h001F, 5: 16'h07FF, 6: 16'hF81F, 7: 16'hFFE0,
      default: 16'h0000
   };

   always_ff @(posedge clk) begin
      if (avs_palette_write) begin
         pal_q[avs_palette_address] <= avs_palette_writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 16'h0000;
      end else begin
         rdata_q <= pal_q[avs_palette_address];
      end
   end

   logic [7:0]  idx8;
   logic [15:0] entry;
   logic [7:0]  nxt_idx_a, nxt_idx_b;
   logic        take_a, take_b, done_a, done_b, search_done;

   assign idx8  = 8'(idx_q);
   assign entry = pal_q[idx8];

`ifdef PALETTE_NEAREST_EN
   function automatic logic [7:0] rgb_dist(input logic [15:0] p, input logic [15:0] q);
      logic [4:0] dr;
      logic [5:0] dg;
      logic [4:0] db;
      dr = (p[15:11] > q[15:11]) ? p[15:11] - q[15:11] : q[15:11] - p[15:11];
      dg = (p[10:5]  > q[10:5])  ? p[10:5]  - q[10:5]  : q[10:5]  - p[10:5];
      db = (p[4:0]   > q[4:0])   ? p[4:0]   - q[4:0]   : q[4:0]   - p[4:0];
      return 8'(dr) + 8'(dg) + 8'(db);
   endfunction

   logic [7:0] best_a_q, best_a_d, best_b_q, best_b_d;
   logic [7:0] dist_a, dist_b, nxt_best_a, nxt_best_b;

   assign dist_a     = rgb_dist(entry, pix_a_q);
   assign dist_b     = rgb_dist(entry, pix_b_q);
   // Strictly-smaller replacement keeps ties on the lowest index.
   assign take_a     = dist_a < best_a_q;
   assign take_b     = dist_b < best_b_q;
   assign nxt_best_a = take_a ? dist_a : best_a_q;
   assign nxt_best_b = take_b ? dist_b : best_b_q;
   assign done_a     = (nxt_best_a == 8'd0);
   assign done_b     = (nxt_best_b == 8'd0);
`else
   logic found_a_q, found_a_d, found_b_q, found_b_d;

   assign take_a = !found_a_q && (entry == pix_a_q);
   assign take_b = !found_b_q && (entry == pix_b_q);
   assign done_a = found_a_q | take_a;
   assign done_b = found_b_q | take_b;
`endif

   assign nxt_idx_a   = take_a ? idx8 : idx_a_q;
   assign nxt_idx_b   = take_b ? idx8 : idx_b_q;
   assign search_done = (done_a && done_b) || (idx_q == LAST);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pix_a_d  = pix_a_q;
      pix_b_d  = pix_b_q;
      idx_a_d  = idx_a_q;
      idx_b_d  = idx_b_q;
      mwrite_d = mwrite_q;
      maddr_d  = maddr_q;
      mdata_d  = mdata_q;
`ifdef PALETTE_NEAREST_EN
      best_a_d = best_a_q;
      best_b_d = best_b_q;
`else
      found_a_d = found_a_q;
      found_b_d = found_b_q;
`endif
      case (state_q)
         IDLE: begin
            if (avs_slave_write) begin
               pix_a_d = avs_slave_writedata[31:16];
               pix_b_d = avs_slave_writedata[15:0];
               maddr_d = {avs_slave_address[22:0], 1'b0};
               idx_d   = '0;
               idx_a_d = DEF8;
               idx_b_d = DEF8;
`ifdef PALETTE_NEAREST_EN
               best_a_d = 8'hFF;
               best_b_d = 8'hFF;
`else
               found_a_d = 1'b0;
               found_b_d = 1'b0;
`endif
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            idx_a_d = nxt_idx_a;
            idx_b_d = nxt_idx_b;
`ifdef PALETTE_NEAREST_EN
            best_a_d = nxt_best_a;
            best_b_d = nxt_best_b;
`else
            found_a_d = done_a;
            found_b_d = done_b;
`endif
            if (search_done) begin
               mwrite_d = 1'b1;
               mdata_d  = {nxt_idx_a, nxt_idx_b};
               state_d  = WRITE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         WRITE: begin
            if (!avm_master_waitrequest) begin
               mwrite_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            mwrite_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         pix_a_q  <= 16'h0000;
         pix_b_q  <= 16'h0000;
         idx_a_q  <= 8'h00;
         idx_b_q  <= 8'h00;
         mwrite_q <= 1'b0;
         maddr_q  <= 24'h000000;
         mdata_q  <= 16'h0000;
`ifdef PALETTE_NEAREST_EN
         best_a_q <= 8'hFF;
         best_b_q <= 8'hFF;
`else
         found_a_q <= 1'b0;
         found_b_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pix_a_q  <= pix_a_d;
         pix_b_q  <= pix_b_d;
         idx_a_q  <= idx_a_d;
         idx_b_q  <= idx_b_d;
         mwrite_q <= mwrite_d;
         maddr_q  <= maddr_d;
         mdata_q  <= mdata_d;
`ifdef PALETTE_NEAREST_EN
         best_a_q <= best_a_d;
         best_b_q <= best_b_d;
`else
         found_a_q <= found_a_d;
         found_b_q <= found_b_d;
`endif
      end
   end

   // Address bit 23 falls off the top when the pair address becomes a byte address.
   logic unused_addr_msb;
   assign unused_addr_msb = avs_slave_address[23];

   assign avs_slave_waitrequest = (state_q != IDLE);
   assign avm_master_write      = mwrite_q;
   assign avm_master_address    = maddr_q;
   assign avm_master_writedata  = mdata_q;
   assign avs_palette_readdata  = rdata_q;
   assign fsm_state_o           = state_q;

endmodule
